mem_req_arbiter: RTL and testbench
==================================

Name: mem_req_arbiter

Overview:
- Shares the single memory port between the instruction-cache subsystem (fetch and prefetch misses) and the data-cache subsystem (load misses and writebacks).
- Each cycle it selects at most one request, drives the memory command bus, and reports acceptance and the issued tag back to the winning requester only.
- It records which requester owns each outstanding load tag, so that returning data/tag pairs are steered to the correct cache.
- It sits between both cache subsystems and mem.

Parameters:
- NUM_TAGS, 15: usable memory tags 1..NUM_TAGS; tag 0 means "no tag / rejected".
- TAG_W, 4: tag width; must satisfy 2^TAG_W > NUM_TAGS.
- STARVE_LIMIT, 4: number of consecutive dcache grants while icache is waiting, after which icache gets priority.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ic_req_valid  in  1  icache requests a block load
- ic_req_addr  in  32  icache block address (bits [2:0] ignored)
- ic_req_accepted  out  1  icache request issued this cycle
- ic_req_tag  out  TAG_W  tag assigned to icache request; 0 when not accepted
- dc_req_cmd  in  2  0=NONE, 1=LOAD, 2=STORE
- dc_req_addr  in  32  dcache block address
- dc_req_data  in  64  store data
- dc_req_accepted  out  1  dcache request issued this cycle
- dc_req_tag  out  TAG_W  tag assigned to dcache request; 0 when not accepted
- mem_cmd  out  2  command to memory
- mem_addr  out  32  address to memory, bits [2:0] forced to 0
- mem_wdata  out  64  store data to memory
- mem_trans_tag  in  TAG_W  tag returned by memory for the current command; 0 means rejected
- mem_rdata  in  64  returned block
- mem_rdata_tag  in  TAG_W  tag of the returned block; 0 means none
- ic_rdata_tag  out  TAG_W  mem_rdata_tag if the tag is owned by icache, else 0
- dc_rdata_tag  out  TAG_W  mem_rdata_tag if the tag is owned by dcache, else 0
- rdata  out  64  mem_rdata, passed through

Behaviour:
- State:
  - owner[1..NUM_TAGS]: 2-bit code per tag; FREE / IC / DC.
  - starve_cnt: 0..STARVE_LIMIT.
  - outstanding: 0..NUM_TAGS; counts load tags that are not FREE.
- Reset (asynchronous): owner = all FREE, starve_cnt = 0, outstanding = 0. While reset is high, every output is 0: mem_cmd NONE, accepted 0, tags 0, rdata 0.
- Issue blocking:
  - If outstanding == NUM_TAGS, no LOAD is issued.
  - A dcache STORE may still issue while loads are blocked.
- Selection (combinational, same cycle):
  - Default priority is dcache first.
  - Icache wins instead if starve_cnt == STARVE_LIMIT and ic_req_valid is high.
  - The loser sees accepted = 0 and tag = 0.
  - mem_cmd/addr/wdata come from the winner. With no winner, mem_cmd = NONE.
- Acceptance:
  - Winner's accepted = (mem_trans_tag != 0) and mem_cmd != NONE.
  - Winner's tag = mem_trans_tag.
  - Rejection (tag 0) changes no state except starve_cnt.
- Allocation on the clock edge:
  - An accepted LOAD writes owner[tag] = IC or DC and increments outstanding.
  - An accepted STORE allocates nothing.
- Return:
  - When mem_rdata_tag != 0 and owner[mem_rdata_tag] != FREE, drive the matching side's *_rdata_tag combinationally.
  - At the edge, set that owner entry to FREE and decrement outstanding.
  - A returning tag that is already FREE produces no output and no state change. This is a memory protocol error; flag it in assertions.
- Simultaneous return and accept in the same cycle:
  - Routing uses the pre-edge owner value.
  - At the edge, allocation wins over free if both target the same tag.
  - outstanding changes by net 0.
- starve_cnt update:
  - +1, saturating at STARVE_LIMIT, when dcache is accepted while ic_req_valid is high.
  - Cleared to 0 when icache is accepted, or when ic_req_valid is low.
  - Held otherwise.
- Latency: request to accept is 0 cycles; return to routed tag is 0 cycles. Requesters must hold the request until accepted.

Optional Feature:
- MEM_ARB_ROUND_ROBIN_EN defined:
  - starve_cnt is removed.
  - A 1-bit last_winner register (reset value: icache) selects priority: the requester that did not last win an accepted request is favoured.
  - last_winner updates only on acceptance.
- Undefined: dcache-priority-with-starvation policy as described above.

Test Plan:
- Single icache LOAD, addr 0x1004, mem_trans_tag=3 -> ic_req_accepted=1, ic_req_tag=3, mem_addr=0x1000, mem_cmd=1.
  - Later mem_rdata_tag=3 -> ic_rdata_tag=3, dc_rdata_tag=0, owner[3] FREE next cycle.
- Both requesting continuously, STARVE_LIMIT=4, memory always accepts -> dcache granted 4 cycles, icache on the 5th, then dcache again.
- Fill all 15 tags with loads -> 16th LOAD not issued (mem_cmd=0, accepted=0).
  - In the same full state, a dcache STORE -> still issued.
  - After one tag returns -> the LOAD issues next cycle.
- Same-cycle return of tag 5 (owner IC) and accept of a new dcache LOAD with tag 5 -> ic_rdata_tag=5 this cycle; owner[5]=DC afterwards; outstanding unchanged.
- mem_trans_tag=0 on a dcache LOAD -> dc_req_accepted=0, dc_req_tag=0, no allocation; request held and accepted the next cycle with tag 7.
- Assert reset mid-operation with 6 tags outstanding -> all outputs 0 immediately; outstanding=0 and a later return of an old tag routes nowhere.

Source files
------------

// File: rtl/mem_req_arbiter_if.sv
// Request, memory command and read-return signals shared by mem_req_arbiter and its neighbours.
// slave is the arbiter's view; master is the caches/memory side.
interface mem_req_arbiter_if #(
    parameter int unsigned TAG_W = 4
) ();
    logic             ic_req_valid;
    logic [31:0]      ic_req_addr;
    logic             ic_req_accepted;
    logic [TAG_W-1:0] ic_req_tag;

    logic [1:0]       dc_req_cmd;
    logic [31:0]      dc_req_addr;
    logic [63:0]      dc_req_data;
    logic             dc_req_accepted;
    logic [TAG_W-1:0] dc_req_tag;

    logic [1:0]       mem_cmd;
    logic [31:0]      mem_addr;
    logic [63:0]      mem_wdata;
    logic [TAG_W-1:0] mem_trans_tag;
    logic [63:0]      mem_rdata;
    logic [TAG_W-1:0] mem_rdata_tag;

    logic [TAG_W-1:0] ic_rdata_tag;
    logic [TAG_W-1:0] dc_rdata_tag;
    logic [63:0]      rdata;

    modport slave (
        input  ic_req_valid, ic_req_addr, dc_req_cmd, dc_req_addr, dc_req_data,
        input  mem_trans_tag, mem_rdata, mem_rdata_tag,
        output ic_req_accepted, ic_req_tag, dc_req_accepted, dc_req_tag,
        output mem_cmd, mem_addr, mem_wdata, ic_rdata_tag, dc_rdata_tag, rdata
    );

    modport master (
        output ic_req_valid, ic_req_addr, dc_req_cmd, dc_req_addr, dc_req_data,
        output mem_trans_tag, mem_rdata, mem_rdata_tag,
        input  ic_req_accepted, ic_req_tag, dc_req_accepted, dc_req_tag,
        input  mem_cmd, mem_addr, mem_wdata, ic_rdata_tag, dc_rdata_tag, rdata
    );
endinterface

// File: rtl/mem_req_arbiter.sv
// Shares one memory port between icache and dcache, and steers returning tags to their owner.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin priority instead of dcache-first with starvation.
module mem_req_arbiter #(
    parameter int unsigned NUM_TAGS     = 15,
    parameter int unsigned TAG_W        = 4,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic             clock,
    input logic             reset,
    mem_req_arbiter_if.slave bus
);
    localparam int unsigned NumEntries = 2 ** TAG_W;
    localparam int unsigned OutW       = $clog2(NUM_TAGS + 1);
    localparam logic [OutW-1:0]  OutMax  = OutW'(NUM_TAGS);
    localparam logic [TAG_W-1:0] TagMax  = TAG_W'(NUM_TAGS);
    localparam logic [1:0] CmdNone  = 2'd0;
    localparam logic [1:0] CmdLoad  = 2'd1;
    localparam logic [1:0] CmdStore = 2'd2;

    typedef enum logic [1:0] {OwnFree = 2'd0, OwnIc = 2'd1, OwnDc = 2'd2} owner_e;

    owner_e          owner_q [NumEntries];
    owner_e          owner_d [NumEntries];
    logic [OutW-1:0] outstanding_q, outstanding_d;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_ic_q, last_ic_d;
`else
    localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);
    localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);
    logic [StarveW-1:0] starve_q, starve_d;
`endif

    logic loads_blocked, dc_is_load, ic_can, dc_can, ic_prio, ic_win, dc_win;
    logic tag_ok, ic_acc, dc_acc, ret_hit, ret_unowned, alloc_bad;
    logic [TAG_W-1:0] ret_tag, acc_tag;
    owner_e ret_owner;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.ic_req_addr[2:0], bus.dc_req_addr[2:0]};

    always_comb begin
        loads_blocked = (outstanding_q == OutMax);
        dc_is_load    = (bus.dc_req_cmd == CmdLoad);
        ic_can        = bus.ic_req_valid && !loads_blocked;
        // Stores carry no tag ownership, so they bypass the load limit.
        dc_can        = (dc_is_load && !loads_blocked) || (bus.dc_req_cmd == CmdStore);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        ic_prio       = !last_ic_q;
`else
        ic_prio       = (starve_q == StarveMax);
`endif
        ic_win        = ic_can && (ic_prio || !dc_can);
        dc_win        = dc_can && !ic_win;
        acc_tag       = bus.mem_trans_tag;
        tag_ok        = (acc_tag != '0);
        ic_acc        = ic_win && tag_ok;
        dc_acc        = dc_win && tag_ok;

        ret_tag       = bus.mem_rdata_tag;
        ret_owner     = owner_q[ret_tag];
        ret_hit       = (ret_tag != '0) && (ret_owner != OwnFree);
        ret_unowned   = (ret_tag != '0) && (ret_owner == OwnFree);
        alloc_bad     = (ic_acc || (dc_acc && dc_is_load)) &&
                        ((acc_tag > TagMax) ||
                         ((owner_q[acc_tag] != OwnFree) && !(ret_hit && ret_tag == acc_tag)));
    end

    // All outputs are held at zero while reset is asserted.
    always_comb begin
        bus.mem_cmd         = CmdNone;
        bus.mem_addr        = '0;
        bus.mem_wdata       = '0;
        bus.ic_req_accepted = 1'b0;
        bus.ic_req_tag      = '0;
        bus.dc_req_accepted = 1'b0;
        bus.dc_req_tag      = '0;
        bus.ic_rdata_tag    = '0;
        bus.dc_rdata_tag    = '0;
        bus.rdata           = '0;
        if (!reset) begin
            if (ic_win) begin
                bus.mem_cmd  = CmdLoad;
                bus.mem_addr = {bus.ic_req_addr[31:3], 3'b000};
            end else if (dc_win) begin
                bus.mem_cmd   = bus.dc_req_cmd;
                bus.mem_addr  = {bus.dc_req_addr[31:3], 3'b000};
                bus.mem_wdata = bus.dc_req_data;
            end
            bus.ic_req_accepted = ic_acc;
            bus.ic_req_tag      = ic_acc ? acc_tag : '0;
            bus.dc_req_accepted = dc_acc;
            bus.dc_req_tag      = dc_acc ? acc_tag : '0;
            bus.ic_rdata_tag    = (ret_hit && ret_owner == OwnIc) ? ret_tag : '0;
            bus.dc_rdata_tag    = (ret_hit && ret_owner == OwnDc) ? ret_tag : '0;
            bus.rdata           = bus.mem_rdata;
        end
    end

    always_comb begin
        owner_d       = owner_q;
        outstanding_d = outstanding_q;
        if (ret_hit) begin
            owner_d[ret_tag] = OwnFree;
            outstanding_d    = outstanding_d - OutW'(1);
        end
        // Allocation is applied after the free so a reused tag ends up owned.
        if (ic_acc) begin
            owner_d[acc_tag] = OwnIc;
            outstanding_d    = outstanding_d + OutW'(1);
        end else if (dc_acc && dc_is_load) begin
            owner_d[acc_tag] = OwnDc;
            outstanding_d    = outstanding_d + OutW'(1);
        end
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    always_comb begin
        last_ic_d = last_ic_q;
        if (ic_acc)      last_ic_d = 1'b1;
        else if (dc_acc) last_ic_d = 1'b0;
    end
`else
    always_comb begin
        starve_d = starve_q;
        if (!bus.ic_req_valid || ic_acc) starve_d = '0;
        else if (dc_acc && starve_q != StarveMax) starve_d = starve_q + StarveW'(1);
    end
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NumEntries; i++) owner_q[i] <= OwnFree;
            outstanding_q <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_ic_q     <= 1'b1;
`else
            starve_q      <= '0;
`endif
        end else begin
            owner_q       <= owner_d;
            outstanding_q <= outstanding_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_ic_q     <= last_ic_d;
`else
            starve_q      <= starve_d;
`endif
        end
    end

    // Returning a tag nobody owns is a memory protocol error; it is ignored by the logic.
    a_return_owned: assert property (@(posedge clock) disable iff (reset) !ret_unowned)
        else $warning("mem_req_arbiter: return of unowned tag %0d", ret_tag);
    a_alloc_free: assert property (@(posedge clock) disable iff (reset) !alloc_bad)
        else $error("mem_req_arbiter: load accepted with tag %0d already in use", acc_tag);
endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter in its default (dcache-first with starvation) build.
module tb_mem_req_arbiter;
    logic clock = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    mem_req_arbiter_if #(.TAG_W(4)) bus ();

    mem_req_arbiter #(.NUM_TAGS(15), .TAG_W(4), .STARVE_LIMIT(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_idle();
        bus.ic_req_valid  = 1'b0;
        bus.ic_req_addr   = '0;
        bus.dc_req_cmd    = 2'd0;
        bus.dc_req_addr   = '0;
        bus.dc_req_data   = '0;
        bus.mem_trans_tag = '0;
        bus.mem_rdata     = '0;
        bus.mem_rdata_tag = '0;
    endtask

    // Each vector: drive after the falling edge, sample 1ns later, state updates on the rising edge.
    initial begin
        logic [1:0] exp_win [6];
        exp_win = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd2};

        reset = 1'b1;
        set_idle();
        bus.ic_req_valid  = 1'b1;
        bus.ic_req_addr   = 32'h0000_1004;
        bus.mem_trans_tag = 4'd3;
        bus.mem_rdata     = 64'h1111_2222_3333_4444;
        bus.mem_rdata_tag = 4'd2;
        #2;
        check_eq("rst_mem_cmd", bus.mem_cmd, 0);
        check_eq("rst_ic_acc", bus.ic_req_accepted, 0);
        check_eq("rst_ic_tag", bus.ic_req_tag, 0);
        check_eq("rst_rdata", bus.rdata, 0);
        check_eq("rst_mem_addr", bus.mem_addr, 0);

        @(negedge clock);
        reset = 1'b0;
        set_idle();

        // Single icache load
        @(negedge clock);
        bus.ic_req_valid  = 1'b1;
        bus.ic_req_addr   = 32'h0000_1004;
        bus.mem_trans_tag = 4'd3;
        #1;
        check_eq("ic_acc", bus.ic_req_accepted, 1);
        check_eq("ic_tag", bus.ic_req_tag, 3);
        check_eq("ic_mem_addr", bus.mem_addr, 32'h0000_1000);
        check_eq("ic_mem_cmd", bus.mem_cmd, 1);
        check_eq("ic_dc_acc", bus.dc_req_accepted, 0);

        @(negedge clock);
        set_idle();
        bus.mem_rdata     = 64'hcafe_f00d_0123_4567;
        bus.mem_rdata_tag = 4'd3;
        #1;
        check_eq("ret3_ic_tag", bus.ic_rdata_tag, 3);
        check_eq("ret3_dc_tag", bus.dc_rdata_tag, 0);
        check_eq("ret3_rdata", bus.rdata, 64'hcafe_f00d_0123_4567);

        // Both requesting: dcache x4, icache, dcache
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            set_idle();
            bus.ic_req_valid  = 1'b1;
            bus.ic_req_addr   = 32'h0000_4000;
            bus.dc_req_cmd    = 2'd1;
            bus.dc_req_addr   = 32'h0000_8000;
            bus.mem_trans_tag = 4'(i + 1);
            #1;
            check_eq($sformatf("starve_ic_acc[%0d]", i), bus.ic_req_accepted, exp_win[i] == 2'd1);
            check_eq($sformatf("starve_dc_acc[%0d]", i), bus.dc_req_accepted, exp_win[i] == 2'd2);
        end
        // Owners now: 1-4 DC, 5 IC, 6 DC

        // Tag 5 freed by return and reallocated to dcache in the same cycle
        @(negedge clock);
        set_idle();
        bus.dc_req_cmd    = 2'd1;
        bus.dc_req_addr   = 32'h0000_9000;
        bus.mem_trans_tag = 4'd5;
        bus.mem_rdata_tag = 4'd5;
        #1;
        check_eq("same_ic_rtag", bus.ic_rdata_tag, 5);
        check_eq("same_dc_rtag", bus.dc_rdata_tag, 0);
        check_eq("same_dc_acc", bus.dc_req_accepted, 1);
        check_eq("same_dc_tag", bus.dc_req_tag, 5);

        @(negedge clock);
        set_idle();
        bus.mem_rdata_tag = 4'd5;
        #1;
        check_eq("re5_dc_rtag", bus.dc_rdata_tag, 5);
        check_eq("re5_ic_rtag", bus.ic_rdata_tag, 0);

        // Memory rejects a dcache load, then accepts it with tag 7
        @(negedge clock);
        set_idle();
        bus.dc_req_cmd    = 2'd1;
        bus.dc_req_addr   = 32'h0000_a008;
        bus.mem_trans_tag = 4'd0;
        #1;
        check_eq("rej_dc_acc", bus.dc_req_accepted, 0);
        check_eq("rej_dc_tag", bus.dc_req_tag, 0);
        check_eq("rej_mem_cmd", bus.mem_cmd, 1);

        @(negedge clock);
        bus.mem_trans_tag = 4'd7;
        #1;
        check_eq("retry_dc_acc", bus.dc_req_accepted, 1);
        check_eq("retry_dc_tag", bus.dc_req_tag, 7);
        check_eq("retry_mem_addr", bus.mem_addr, 32'h0000_a008);
        // Outstanding: 1,2,3,4,6,7

        // Asynchronous reset mid-cycle with 6 tags outstanding
        @(negedge clock);
        set_idle();
        bus.dc_req_cmd    = 2'd1;
        bus.dc_req_addr   = 32'h0000_b000;
        bus.mem_trans_tag = 4'd8;
        bus.mem_rdata     = 64'h5555_6666_7777_8888;
        bus.mem_rdata_tag = 4'd6;
        #1;
        check_eq("pre_rst_dc_rtag", bus.dc_rdata_tag, 6);
        reset = 1'b1;
        #1;
        check_eq("mid_rst_mem_cmd", bus.mem_cmd, 0);
        check_eq("mid_rst_dc_acc", bus.dc_req_accepted, 0);
        check_eq("mid_rst_dc_tag", bus.dc_req_tag, 0);
        check_eq("mid_rst_dc_rtag", bus.dc_rdata_tag, 0);
        check_eq("mid_rst_rdata", bus.rdata, 0);
        @(negedge clock);
        reset = 1'b0;
        set_idle();

        @(negedge clock);
        bus.mem_rdata_tag = 4'd6;
        #1;
        check_eq("stale_dc_rtag", bus.dc_rdata_tag, 0);
        check_eq("stale_ic_rtag", bus.ic_rdata_tag, 0);

        // Fill all 15 tags from an empty table
        for (int t = 1; t <= 15; t++) begin
            @(negedge clock);
            set_idle();
            bus.dc_req_cmd    = 2'd1;
            bus.dc_req_addr   = 32'(t * 64);
            bus.mem_trans_tag = 4'(t);
            #1;
            check_eq($sformatf("fill_acc[%0d]", t), bus.dc_req_accepted, 1);
        end

        @(negedge clock);
        set_idle();
        bus.dc_req_cmd    = 2'd1;
        bus.dc_req_addr   = 32'h0000_c000;
        bus.mem_trans_tag = 4'd1;
        #1;
        check_eq("full_mem_cmd", bus.mem_cmd, 0);
        check_eq("full_dc_acc", bus.dc_req_accepted, 0);

        @(negedge clock);
        set_idle();
        bus.ic_req_valid  = 1'b1;
        bus.ic_req_addr   = 32'h0000_d000;
        bus.mem_trans_tag = 4'd1;
        #1;
        check_eq("full_ic_cmd", bus.mem_cmd, 0);
        check_eq("full_ic_acc", bus.ic_req_accepted, 0);

        @(negedge clock);
        set_idle();
        bus.dc_req_cmd    = 2'd2;
        bus.dc_req_addr   = 32'h2000_0abc;
        bus.dc_req_data   = 64'hdead_beef_0bad_f00d;
        bus.mem_trans_tag = 4'd9;
        #1;
        check_eq("full_st_cmd", bus.mem_cmd, 2);
        check_eq("full_st_acc", bus.dc_req_accepted, 1);
        check_eq("full_st_addr", bus.mem_addr, 32'h2000_0ab8);
        check_eq("full_st_wdata", bus.mem_wdata, 64'hdead_beef_0bad_f00d);

        // Return of tag 8 unblocks the pending load on the following cycle
        @(negedge clock);
        set_idle();
        bus.dc_req_cmd    = 2'd1;
        bus.dc_req_addr   = 32'h0000_c000;
        bus.mem_trans_tag = 4'd8;
        bus.mem_rdata_tag = 4'd8;
        #1;
        check_eq("unblk_rtag", bus.dc_rdata_tag, 8);
        check_eq("unblk_same_cmd", bus.mem_cmd, 0);

        @(negedge clock);
        bus.mem_rdata_tag = 4'd0;
        #1;
        check_eq("unblk_cmd", bus.mem_cmd, 1);
        check_eq("unblk_acc", bus.dc_req_accepted, 1);
        check_eq("unblk_tag", bus.dc_req_tag, 8);

        @(negedge clock);
        set_idle();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
